tag_free_list: RTL and testbench

Physical-tag free list for the rename stage. It supplies up to NUM_ISSUE fresh physical tags per cycle to rename, where they are written as speculative mappings. It takes back previous committed tags released at commit. On a mispredict it restores all speculatively allocated, uncommitted tags. It is the producer of the rename table's issue tags and the consumer of its commit previous-tag outputs.

---
 rtl/tag_free_list_pkg.sv | 17 +
 rtl/tag_free_list_popcount_prefix.sv | 21 ++
 rtl/tag_free_list.sv | 152 +++++++++++++++
 tb/tb_tag_free_list.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tag_free_list_pkg.sv
// Shared rename constants and tag type used by the free list, rename table and ROB.
package tag_free_list_pkg;

    localparam int TAG_SIZE   = 7;
    localparam int NUM_REGS   = 64;
    localparam int DEPTH      = 2 ** TAG_SIZE - NUM_REGS;
    localparam int NUM_ISSUE  = 3;
    localparam int NUM_COMMIT = 3;

    typedef bit [TAG_SIZE-1:0] Tag_t;

    // A valid vector is contiguous from slot 0 when it has the form 0..01..1.
    function automatic bit is_contiguous(input logic [7:0] v);
        return ((v & (v + 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/tag_free_list_popcount_prefix.sv
// Exclusive prefix popcount: rank[i] is the number of set bits below slot i.
module popcount_prefix #(
    parameter int N  = 3,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  valid,
    output logic [CW-1:0] rank [N],
    output logic [CW-1:0] count
);

    always_comb begin
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            rank[i] = acc;
            acc     = acc + CW'(valid[i]);
        end
        count = acc;
    end

endmodule

// File: rtl/tag_free_list.sv
// Physical-tag free list for rename: circular buffer with write, speculative-read and committed-read pointers.
// Optional in-list scoreboard and legality checks enabled by defining TAG_FREE_LIST_CHECK_EN.
module tag_free_list
    import tag_free_list_pkg::*;
#(
    parameter int NUM_ISSUE  = tag_free_list_pkg::NUM_ISSUE,
    parameter int NUM_COMMIT = tag_free_list_pkg::NUM_COMMIT,
    parameter int NUM_REGS   = tag_free_list_pkg::NUM_REGS,
    parameter int TAG_SIZE   = tag_free_list_pkg::TAG_SIZE,
    parameter int DEPTH      = 2 ** TAG_SIZE - NUM_REGS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IN_mispred,
    output logic [TAG_SIZE-1:0]        OUT_issueTags     [NUM_ISSUE],
    output logic                       OUT_issueTagValid [NUM_ISSUE],
    input  logic                       IN_issueValid     [NUM_ISSUE],
    input  logic                       IN_commitValid    [NUM_COMMIT],
    input  logic [TAG_SIZE-1:0]        IN_commitPrevTags [NUM_COMMIT],
    output logic [$clog2(DEPTH):0]     OUT_freeCount
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(NUM_ISSUE + 1);
    localparam int KW = $clog2(NUM_COMMIT + 1);

    logic [TAG_SIZE-1:0]   tag_buf [DEPTH];
    logic [PW-1:0]         wptr, srptr, crptr;
    logic [PW-1:0]         free_count;

    logic [NUM_ISSUE-1:0]  issue_mask;
    logic [NUM_COMMIT-1:0] commit_mask;
    logic [CW-1:0]         issue_rank_unused [NUM_ISSUE];
    logic [CW-1:0]         alloc_count;
    logic [KW-1:0]         commit_rank [NUM_COMMIT];
    logic [KW-1:0]         commit_count;

    assign free_count    = wptr - srptr;
    assign OUT_freeCount = free_count;

    // Slots without a backing tag are ignored even if rename asserts them.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ISSUE; i++) begin
            idx                  = srptr + PW'(i);
            OUT_issueTags[i]     = tag_buf[idx[IW-1:0]];
            OUT_issueTagValid[i] = free_count > PW'(i);
            issue_mask[i]        = IN_issueValid[i] && OUT_issueTagValid[i];
        end
        for (int k = 0; k < NUM_COMMIT; k++) begin
            commit_mask[k] = IN_commitValid[k];
        end
    end

    popcount_prefix #(.N(NUM_ISSUE), .CW(CW)) u_issue_count (
        .valid (issue_mask),
        .rank  (issue_rank_unused),
        .count (alloc_count)
    );

    popcount_prefix #(.N(NUM_COMMIT), .CW(KW)) u_commit_count (
        .valid (commit_mask),
        .rank  (commit_rank),
        .count (commit_count)
    );

    // Frees always land, even on a mispredict; rollback rewinds srptr past this cycle's commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_buf[i] <= TAG_SIZE'(NUM_REGS + i);
            end
            wptr  <= PW'(DEPTH);
            srptr <= '0;
            crptr <= '0;
        end else begin
            for (int k = 0; k < NUM_COMMIT; k++) begin
                if (commit_mask[k]) begin
                    tag_buf[IW'(wptr + PW'(commit_rank[k]))] <= IN_commitPrevTags[k];
                end
            end
            wptr  <= wptr + PW'(commit_count);
            crptr <= crptr + PW'(commit_count);
            if (IN_mispred) begin
                srptr <= crptr + PW'(commit_count);
            end else begin
                srptr <= srptr + PW'(alloc_count);
            end
        end
    end

`ifdef TAG_FREE_LIST_CHECK_EN
    logic [2**TAG_SIZE-1:0] in_list, in_list_next;

    always_comb begin
        logic [PW-1:0] idx;
        logic [PW-1:0] keep;
        idx          = '0;
        keep         = wptr - crptr - PW'(commit_count);
        in_list_next = in_list;
        if (IN_mispred) begin
            in_list_next = '0;
            for (int j = 0; j < DEPTH; j++) begin
                idx = crptr + PW'(commit_count) + PW'(j);
                if (PW'(j) < keep) begin
                    in_list_next[tag_buf[idx[IW-1:0]]] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < NUM_ISSUE; i++) begin
                if (issue_mask[i]) begin
                    in_list_next[OUT_issueTags[i]] = 1'b0;
                end
            end
        end
        for (int k = 0; k < NUM_COMMIT; k++) begin
            if (commit_mask[k]) begin
                in_list_next[IN_commitPrevTags[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < 2 ** TAG_SIZE; t++) begin
                in_list[t] <= (t >= NUM_REGS) && (t < NUM_REGS + DEPTH);
            end
        end else begin
            in_list <= in_list_next;
            for (int k = 0; k < NUM_COMMIT; k++) begin
                if (commit_mask[k] && in_list[IN_commitPrevTags[k]]) begin
                    $error("tag_free_list: tag %0d freed while already in list", IN_commitPrevTags[k]);
                end
            end
            if ((PW + 1)'(free_count) + (PW + 1)'(commit_count) > (PW + 1)'(DEPTH)) begin
                $error("tag_free_list: free would exceed capacity");
            end
            for (int i = 0; i < NUM_ISSUE; i++) begin
                if (IN_issueValid[i] && !OUT_issueTagValid[i]) begin
                    $error("tag_free_list: allocation of invalid slot %0d", i);
                end
            end
            if (!is_contiguous(8'(issue_mask)) || !is_contiguous(8'(commit_mask))) begin
                $error("tag_free_list: non-contiguous valid vector");
            end
        end
    end
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list: directed vector table, corner sequences and a queue-model stream.
module tb_tag_free_list;
    import tag_free_list_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       IN_mispred;
    logic [6:0] OUT_issueTags     [3];
    logic       OUT_issueTagValid [3];
    logic       IN_issueValid     [3];
    logic       IN_commitValid    [3];
    logic [6:0] IN_commitPrevTags [3];
    logic [6:0] OUT_freeCount;

    int checks = 0;
    int errors = 0;

    tag_free_list dut (
        .clk               (clk),
        .rst               (rst),
        .IN_mispred        (IN_mispred),
        .OUT_issueTags     (OUT_issueTags),
        .OUT_issueTagValid (OUT_issueTagValid),
        .IN_issueValid     (IN_issueValid),
        .IN_commitValid    (IN_commitValid),
        .IN_commitPrevTags (IN_commitPrevTags),
        .OUT_freeCount     (OUT_freeCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] issue_valid;
        logic [2:0] commit_valid;
        logic [6:0] prev0;
        logic [6:0] prev1;
        logic       mispred;
        logic [6:0] exp_tag0;
        logic [6:0] exp_tag1;
        logic [6:0] exp_free;
    } Vec_t;

    Vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveInputs(input logic [2:0] iv, input logic [2:0] cv,
                               input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                               input logic mp);
        for (int i = 0; i < 3; i++) begin
            IN_issueValid[i]  = iv[i];
            IN_commitValid[i] = cv[i];
        end
        IN_commitPrevTags[0] = p0;
        IN_commitPrevTags[1] = p1;
        IN_commitPrevTags[2] = p2;
        IN_mispred           = mp;
    endtask

    task automatic applyStimulus(input logic [2:0] iv, input logic [2:0] cv,
                                 input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                                 input logic mp);
        driveInputs(iv, cv, p0, p1, p2, mp);
        @(posedge clk);
        #1;
        driveInputs(3'b000, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
    endtask

    task automatic doReset();
        driveInputs(3'b111, 3'b111, 7'd1, 7'd2, 7'd3, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        driveInputs(3'b000, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        Tag_t free_q[$];
        Tag_t spec_q[$];
        Tag_t mapped_q[$];
        Tag_t freed_q[$];
        Tag_t alloc_q[$];
        logic [2:0] iv, cv;
        logic [6:0] p [3];
        logic mp;
        int n, k, lim;

        rst = 1'b0;
        driveInputs(3'b000, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        @(posedge clk);
        #1;

        // Reset state
        doReset();
        checkOutput("reset_tag0", OUT_issueTags[0], 64);
        checkOutput("reset_tag1", OUT_issueTags[1], 65);
        checkOutput("reset_tag2", OUT_issueTags[2], 66);
        for (int i = 0; i < 3; i++) checkOutput($sformatf("reset_valid%0d", i), OUT_issueTagValid[i], 1);
        checkOutput("reset_free", OUT_freeCount, 64);

        // Directed vector table, applied back to back from reset
        vecs[0] = '{3'b111, 3'b000, 7'd0,  7'd0,  1'b0, 7'd67, 7'd68, 7'd61};
        vecs[1] = '{3'b001, 3'b000, 7'd0,  7'd0,  1'b0, 7'd68, 7'd69, 7'd60};
        vecs[2] = '{3'b000, 3'b001, 7'd10, 7'd0,  1'b0, 7'd68, 7'd69, 7'd61};
        vecs[3] = '{3'b011, 3'b011, 7'd11, 7'd12, 1'b0, 7'd70, 7'd71, 7'd61};
        vecs[4] = '{3'b000, 3'b000, 7'd0,  7'd0,  1'b1, 7'd67, 7'd68, 7'd64};
        vecs[5] = '{3'b111, 3'b000, 7'd0,  7'd0,  1'b0, 7'd70, 7'd71, 7'd61};
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].issue_valid, vecs[v].commit_valid, vecs[v].prev0, vecs[v].prev1, 7'd0, vecs[v].mispred);
            checkOutput($sformatf("vec%0d_tag0", v), OUT_issueTags[0], vecs[v].exp_tag0);
            checkOutput($sformatf("vec%0d_tag1", v), OUT_issueTags[1], vecs[v].exp_tag1);
            checkOutput($sformatf("vec%0d_free", v), OUT_freeCount, vecs[v].exp_free);
        end

        // Drain to one, then empty
        doReset();
        repeat (21) applyStimulus(3'b111, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        checkOutput("drain_free1", OUT_freeCount, 1);
        checkOutput("drain_valid0", OUT_issueTagValid[0], 1);
        checkOutput("drain_valid1", OUT_issueTagValid[1], 0);
        checkOutput("drain_valid2", OUT_issueTagValid[2], 0);
        checkOutput("drain_tag127", OUT_issueTags[0], 127);
        applyStimulus(3'b001, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        checkOutput("empty_free", OUT_freeCount, 0);
        checkOutput("empty_valid0", OUT_issueTagValid[0], 0);

        // Free into an empty list: no same-cycle bypass
        driveInputs(3'b000, 3'b011, 7'd5, 7'd9, 7'd0, 1'b0);
        #1;
        checkOutput("bypass_valid0", OUT_issueTagValid[0], 0);
        checkOutput("bypass_free", OUT_freeCount, 0);
        @(posedge clk);
        #1;
        driveInputs(3'b000, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        checkOutput("refill_tag0", OUT_issueTags[0], 5);
        checkOutput("refill_tag1", OUT_issueTags[1], 9);
        checkOutput("refill_free", OUT_freeCount, 2);

        // Allocate six, commit one, then roll back
        doReset();
        applyStimulus(3'b111, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        applyStimulus(3'b111, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        applyStimulus(3'b000, 3'b001, 7'd20, 7'd0, 7'd0, 1'b0);
        checkOutput("rb_pre_free", OUT_freeCount, 59);
        applyStimulus(3'b000, 3'b000, 7'd0, 7'd0, 7'd0, 1'b1);
        checkOutput("rb_tag0", OUT_issueTags[0], 65);
        checkOutput("rb_free", OUT_freeCount, 64);

        // Mispredict together with allocations and commits
        doReset();
        applyStimulus(3'b111, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        applyStimulus(3'b011, 3'b011, 7'd3, 7'd4, 7'd0, 1'b1);
        checkOutput("mpmix_free", OUT_freeCount, 64);
        checkOutput("mpmix_tag0", OUT_issueTags[0], 66);
        repeat (20) applyStimulus(3'b111, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        checkOutput("mpmix_tag126", OUT_issueTags[0], 126);
        applyStimulus(3'b011, 3'b000, 7'd0, 7'd0, 7'd0, 1'b0);
        checkOutput("mpmix_app_free", OUT_freeCount, 2);
        checkOutput("mpmix_app_tag0", OUT_issueTags[0], 3);
        checkOutput("mpmix_app_tag1", OUT_issueTags[1], 4);

        // Queue-model stream with rollbacks
        doReset();
        for (int t = 64; t < 128; t++) free_q.push_back(Tag_t'(t));
        for (int t = 0; t < 64; t++) mapped_q.push_back(Tag_t'(t));
        for (int cyc = 0; cyc < 2000; cyc++) begin
            checkOutput("rnd_free", OUT_freeCount, free_q.size());
            checkOutput("rnd_conserve", 32'(OUT_freeCount) + spec_q.size(), 64);
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("rnd_valid%0d", i), OUT_issueTagValid[i], i < free_q.size());
                if (i < free_q.size()) checkOutput($sformatf("rnd_tag%0d", i), OUT_issueTags[i], free_q[i]);
            end
            lim = (free_q.size() < 3) ? free_q.size() : 3;
            n   = $urandom_range(lim, 0);
            lim = (spec_q.size() < 3) ? spec_q.size() : 3;
            k   = $urandom_range(lim, 0);
            mp  = ($urandom_range(15, 0) == 0);
            iv  = 3'((1 << n) - 1);
            cv  = 3'((1 << k) - 1);
            freed_q.delete();
            alloc_q.delete();
            for (int j = 0; j < 3; j++) p[j] = 7'd0;
            for (int j = 0; j < k; j++) begin
                p[j] = mapped_q.pop_front();
                freed_q.push_back(p[j]);
                mapped_q.push_back(spec_q.pop_front());
            end
            applyStimulus(iv, cv, p[0], p[1], p[2], mp);
            if (mp) begin
                free_q = {spec_q, free_q, freed_q};
                spec_q.delete();
            end else begin
                for (int j = 0; j < n; j++) spec_q.push_back(free_q.pop_front());
                free_q = {free_q, freed_q};
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
